// File: rtl/serial_deshift_rx_pkg.sv
// Shared definitions for the serial word link receiver: FSM state encoding and default word width.
package serial_deshift_rx_pkg;

    localparam int BITS_DEFAULT = 5;

    typedef enum logic [1:0] {
        ST_SYNC     = 2'd0,
        ST_DATA     = 2'd1,
        ST_WAIT_EOS = 2'd2
    } rx_state_e;

endpackage

// File: rtl/rx_hold_reg.sv
// One-word valid/ready holding register for received words. A word offered while the
// register is full and not being drained is dropped and reported with a one-cycle overrun pulse.
module rx_hold_reg
    import serial_deshift_rx_pkg::*;
#(
    parameter int W = BITS_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_data,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         overrun
);

    logic [W-1:0] data_q,    data_d;
    logic         valid_q,   valid_d;
    logic         overrun_q, overrun_d;

    // NOTE: every signal assigned in this block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;
        if (load) begin
            // A handshake in the same cycle frees the slot, so the new word replaces the old one.
            if (!valid_q || out_ready) begin
                data_d  = load_data;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign overrun   = overrun_q;

endmodule

// File: rtl/serial_deshift_rx.sv
// Receive end of the single-wire serial word link: deserialises the LSB-first stream framed by
// eos_in, validates frame length and stop bit, and hands good words to a valid/ready holding register.
module serial_deshift_rx
    import serial_deshift_rx_pkg::*;
#(
    parameter int BITS          = BITS_DEFAULT,
    parameter bit SYNC_ON_RESET = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            sdi,
    input  logic            eos_in,
    output logic [BITS-1:0] dout,
    output logic            dout_valid,
    input  logic            dout_ready,
    output logic            frame_err,
    output logic            overrun,
    output logic            synced
);

    localparam int              CNT_W       = $clog2(BITS);
    localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(BITS - 1);
    localparam rx_state_e       RESET_STATE = SYNC_ON_RESET ? ST_DATA : ST_SYNC;

    rx_state_e       state_q,     state_d;
    logic [BITS-1:0] shreg_q,     shreg_d;
    logic [CNT_W-1:0] bit_cnt_q,  bit_cnt_d;
    logic            frame_err_q, frame_err_d;
    logic            deliver;

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        frame_err_d = 1'b0;
        deliver     = 1'b0;

        case (state_q)
            ST_SYNC: begin
                if (eos_in) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                end
            end

            ST_DATA: begin
                if (eos_in) begin
                    // Stop strobe before the word is complete: short frame.
                    frame_err_d = 1'b1;
                    bit_cnt_d   = '0;
                end else begin
                    shreg_d[bit_cnt_q] = sdi;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = ST_WAIT_EOS;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end

            ST_WAIT_EOS: begin
                bit_cnt_d = '0;
                if (eos_in) begin
                    state_d = ST_DATA;
                    if (sdi == shreg_q[BITS-1]) begin
                        deliver = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    // No stop strobe where one was due: framing is lost until the next eos.
                    frame_err_d = 1'b1;
                    state_d     = ST_SYNC;
                end
            end

            default: begin
                state_d   = ST_SYNC;
                bit_cnt_d = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RESET_STATE;
            // NOTE: the shift register is reset like any other flop; its contents reach dout, so it must come up known.
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            frame_err_q <= frame_err_d;
        end
    end

    rx_hold_reg #(
        .W (BITS)
    ) u_hold (
        .clk       (clk),
        .rst       (rst),
        .load      (deliver),
        .load_data (shreg_q),
        .out_data  (dout),
        .out_valid (dout_valid),
        .out_ready (dout_ready),
        .overrun   (overrun)
    );

    assign frame_err = frame_err_q;
    assign synced    = (state_q != ST_SYNC);

endmodule

// File: tb/tb_serial_deshift_rx.sv
// Scoreboard bench for serial_deshift_rx: frame outcomes are queued as stimulus is issued and
// a negedge monitor matches them against frame_err, overrun and newly presented words.
module tb_serial_deshift_rx;

    localparam int BITS = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            sdi;
    logic            eos_in;
    logic            dout_ready;
    logic [BITS-1:0] dout,      ns_dout;
    logic            dout_valid, ns_dout_valid;
    logic            frame_err,  ns_frame_err;
    logic            overrun,    ns_overrun;
    logic            synced,     ns_synced;

    bit rand_ready  = 1'b0;
    bit ready_fixed = 1'b1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit              is_err;
        logic [BITS-1:0] word;
    } exp_t;

    exp_t exp_q[$];

    serial_deshift_rx #(.BITS(BITS), .SYNC_ON_RESET(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .sdi        (sdi),
        .eos_in     (eos_in),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .synced     (synced)
    );

    serial_deshift_rx #(.BITS(BITS), .SYNC_ON_RESET(1'b0)) dut_ns (
        .clk        (clk),
        .rst        (rst),
        .sdi        (sdi),
        .eos_in     (eos_in),
        .dout       (ns_dout),
        .dout_valid (ns_dout_valid),
        .dout_ready (dout_ready),
        .frame_err  (ns_frame_err),
        .overrun    (ns_overrun),
        .synced     (ns_synced)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic push_good(input logic [BITS-1:0] w);
        exp_t e;
        e.is_err = 1'b0;
        e.word   = w;
        exp_q.push_back(e);
    endtask

    task automatic push_err();
        exp_t e;
        e.is_err = 1'b1;
        e.word   = '0;
        exp_q.push_back(e);
    endtask

    // Present one link cycle and return just after the edge that sampled it.
    task automatic drive(input logic b, input logic e);
        sdi    = b;
        eos_in = e;
        @(posedge clk);
        #1;
    endtask

    // nbits data cycles, then either a stop cycle or `extra` further eos=0 cycles.
    task automatic send_frame(input logic [BITS-1:0] w, input int nbits, input bit bad_stop, input int extra);
        for (int i = 0; i < nbits; i++) drive(w[i], 1'b0);
        if (extra > 0) begin
            for (int i = 0; i < extra; i++) drive(1'($urandom_range(0, 1)), 1'b0);
        end else begin
            drive(w[BITS-1] ^ bad_stop, 1'b1);
        end
    endtask

    task automatic send_sync(input int n);
        for (int i = 0; i < n; i++) drive(1'($urandom_range(0, 1)), 1'b0);
        drive(1'($urandom_range(0, 1)), 1'b1);
    endtask

    // Consumer: fixed or random readiness, updated just after each edge.
    initial begin
        dout_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (rand_ready) dout_ready = ($urandom_range(0, 3) != 0);
            else            dout_ready = ready_fixed;
        end
    end

    // Monitor: every outcome leaves the DUT in frame order, one cycle after its eos edge.
    logic            prev_v = 1'b0;
    logic            prev_r = 1'b0;
    logic [BITS-1:0] prev_d = '0;

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst) begin
            exp_q.delete();
            prev_v = 1'b0;
            prev_r = 1'b0;
        end else begin
            if (frame_err || overrun) check("err_ovr_exclusive", {31'd0, frame_err & overrun}, 32'd0);
            if (frame_err) begin
                check("sb_entry_for_frame_err", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("frame_err_kind", {31'd0, e.is_err}, 32'd1);
                end
            end
            if (overrun) begin
                check("overrun_while_full", {31'd0, prev_v & ~prev_r}, 32'd1);
                check("sb_entry_for_overrun", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("overrun_kind", {31'd0, e.is_err}, 32'd0);
                end
            end
            if (dout_valid && (!prev_v || prev_r)) begin
                check("sb_entry_for_word", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("word_kind", {31'd0, e.is_err}, 32'd0);
                    check("word_value", 32'(dout), 32'(e.word));
                end
            end
            if (prev_v && !prev_r) begin
                check("hold_valid_stable", {31'd0, dout_valid}, 32'd1);
                check("hold_data_stable", 32'(dout), 32'(prev_d));
            end
            prev_v = dout_valid;
            prev_r = dout_ready;
            prev_d = dout;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [BITS-1:0] w;
        int              kind;

        sdi    = 1'b0;
        eos_in = 1'b0;
        rst    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_valid", {31'd0, dout_valid}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        check("rst_synced", {31'd0, synced}, 32'd1);
        check("rst_ns_synced", {31'd0, ns_synced}, 32'd0);
        rst = 1'b0;

        // Clean frame straight after reset.
        push_good(5'h16);
        send_frame(5'h16, BITS, 1'b0, 0);
        check("t1_valid", {31'd0, dout_valid}, 32'd1);
        check("t1_dout", 32'(dout), 32'h16);
        check("t1_no_err", {31'd0, frame_err}, 32'd0);

        // Short frame (3 data bits) followed by a clean frame.
        push_err();
        drive(1'b0, 1'b0);
        check("t1_valid_one_cycle", {31'd0, dout_valid}, 32'd0);
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b1);
        check("t2_short_err", {31'd0, frame_err}, 32'd1);
        check("t2_short_no_valid", {31'd0, dout_valid}, 32'd0);
        push_good(5'h0B);
        send_frame(5'h0B, BITS, 1'b0, 0);
        check("t2_dout", 32'(dout), 32'h0B);

        // Long frame: loses sync until the next eos.
        push_err();
        send_frame(5'h0A, BITS, 1'b0, 2);
        check("t3_unsynced", {31'd0, synced}, 32'd0);
        send_sync(BITS);
        check("t3_resynced", {31'd0, synced}, 32'd1);
        push_good(5'h1F);
        send_frame(5'h1F, BITS, 1'b0, 0);
        check("t3_dout", 32'(dout), 32'h1F);

        // Stop bit differs from the last data bit.
        push_err();
        send_frame(5'h10, BITS, 1'b1, 0);
        check("t4_stop_err", {31'd0, frame_err}, 32'd1);
        check("t4_no_valid", {31'd0, dout_valid}, 32'd0);

        // Consumer stalled across two frames: second word is dropped.
        ready_fixed = 1'b0;
        push_good(5'h03);
        send_frame(5'h03, BITS, 1'b0, 0);
        check("t5_first_valid", {31'd0, dout_valid}, 32'd1);
        push_good(5'h1C);
        send_frame(5'h1C, BITS, 1'b0, 0);
        check("t5_overrun", {31'd0, overrun}, 32'd1);
        check("t5_dout_kept", 32'(dout), 32'h03);
        ready_fixed = 1'b1;
        push_err();
        drive(1'b0, 1'b1);
        check("t5_drained", {31'd0, dout_valid}, 32'd0);

        // Reset in mid-frame with a word still pending.
        ready_fixed = 1'b0;
        push_good(5'h07);
        send_frame(5'h07, BITS, 1'b0, 0);
        check("t6_pending", {31'd0, dout_valid}, 32'd1);
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
        rst = 1'b1;
        drive(1'b1, 1'b0);
        check("t6_rst_dout", 32'(dout), 32'd0);
        check("t6_rst_valid", {31'd0, dout_valid}, 32'd0);
        check("t6_rst_err", {31'd0, frame_err}, 32'd0);
        check("t6_rst_ovr", {31'd0, overrun}, 32'd0);
        rst = 1'b0;
        ready_fixed = 1'b1;

        // Receiver without sync-on-reset ignores the first frame.
        push_good(5'h15);
        send_frame(5'h15, BITS, 1'b0, 0);
        check("t6_dout", 32'(dout), 32'h15);
        check("t6_ns_ignored", {31'd0, ns_dout_valid}, 32'd0);
        check("t6_ns_no_err", {31'd0, ns_frame_err | ns_overrun}, 32'd0);
        check("t6_ns_synced", {31'd0, ns_synced}, 32'd1);
        push_good(5'h09);
        send_frame(5'h09, BITS, 1'b0, 0);
        check("t6_ns_valid", {31'd0, ns_dout_valid}, 32'd1);
        check("t6_ns_dout", 32'(ns_dout), 32'h09);

        // Random frame mix with a random consumer.
        rand_ready = 1'b1;
        for (int n = 0; n < 250; n++) begin
            w    = BITS'($urandom);
            kind = int'($urandom_range(0, 9));
            if (kind < 6) begin
                push_good(w);
                send_frame(w, BITS, 1'b0, 0);
            end else if (kind == 6) begin
                push_err();
                send_frame(w, int'($urandom_range(0, BITS - 1)), 1'b0, 0);
            end else if (kind == 7) begin
                push_err();
                send_frame(w, BITS, 1'b1, 0);
            end else begin
                push_err();
                send_frame(w, BITS, 1'b0, int'($urandom_range(1, 3)));
                send_sync(int'($urandom_range(0, 6)));
            end
        end

        rand_ready  = 1'b0;
        ready_fixed = 1'b1;
        repeat (3) begin
            push_err();
            drive(1'b0, 1'b1);
        end
        @(negedge clk);
        #1;
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
